// File: rtl/cp0_intc_pkg.sv
// Shared CP0 definitions: register numbers, field layouts, ExcCodes and the exception vector.
package cp0_intc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned IRQW = 6;
  localparam int unsigned EXCW = 5;

  localparam logic [REGW-1:0] REG_SR    = 5'd12;
  localparam logic [REGW-1:0] REG_CAUSE = 5'd13;
  localparam logic [REGW-1:0] REG_EPC   = 5'd14;
  localparam logic [REGW-1:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [EXCW-1:0] EXC_INT  = 5'd0;
  localparam logic [EXCW-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXCW-1:0] EXC_ADES = 5'd5;
  localparam logic [EXCW-1:0] EXC_RI   = 5'd10;
  localparam logic [EXCW-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180;

  // Only the implemented SR / Cause fields are stored; the rest read as zero.
  typedef struct packed {
    logic [IRQW-1:0] im;
    logic            exl;
    logic            ie;
  } sr_t;

  typedef struct packed {
    logic            bd;
    logic [IRQW-1:0] ip;
    logic [EXCW-1:0] exc_code;
  } cause_t;

  function automatic logic [XLEN-1:0] sr_word(input sr_t s);
    return {16'd0, s.im, 8'd0, s.exl, s.ie};
  endfunction

  function automatic logic [XLEN-1:0] cause_word(input cause_t c);
    return {c.bd, 15'd0, c.ip, 3'd0, c.exc_code, 2'd0};
  endfunction

endpackage

// File: rtl/cp0_intc_if.sv
// M-stage <-> CP0 bundle: mfc0/mtc0 access, exception inputs, interrupt lines and request/EPC back.
interface cp0_intc_if;
  import cp0_intc_pkg::*;

  logic [REGW-1:0] rd_addr;
  logic [REGW-1:0] wr_addr;
  logic [XLEN-1:0] din;
  logic            we;
  logic [XLEN-1:0] pc;
  logic            bd;
  logic            exc_valid;
  logic [EXCW-1:0] exc_code;
  logic            exl_clr;
  logic [IRQW-1:0] hw_int;
  logic            int_req;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] dout;

  modport master (
    output rd_addr, wr_addr, din, we, pc, bd, exc_valid, exc_code, exl_clr, hw_int,
    input  int_req, epc, dout
  );

  modport slave (
    input  rd_addr, wr_addr, din, we, pc, bd, exc_valid, exc_code, exl_clr, hw_int,
    output int_req, epc, dout
  );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception controller: SR, Cause, EPC, PRId, int_req generation
// and victim PC capture for the M stage.
module cp0_intc
  import cp0_intc_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h0000_2016,
  parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
  input logic        clk,
  input logic        reset,
  cp0_intc_if.slave  bus
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [29:0] epc_q, epc_d;

  logic        irq_c;
  logic        exc_c;
  logic        req_c;
  logic [29:0] victim_c;
  logic        unused_pc;

  // Interrupt uses the live lines, not the registered Cause.IP; held low while in reset.
  always_comb begin
    irq_c = (|(bus.hw_int & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    exc_c = bus.exc_valid & ~sr_q.exl;
    req_c = (irq_c | exc_c) & reset;
  end

  // Word-aligned victim PC; a delay-slot instruction restarts at its branch.
  assign victim_c  = bus.bd ? (bus.pc[31:2] - 30'd1) : bus.pc[31:2];
  assign unused_pc = ^bus.pc[1:0];

  always_comb begin
    sr_d       = sr_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    cause_d.ip = bus.hw_int;

    if (req_c) begin
      sr_d.exl         = 1'b1;
      cause_d.bd       = bus.bd;
      cause_d.exc_code = irq_c ? EXC_INT : bus.exc_code;
      epc_d            = victim_c;
    end else if (bus.we) begin
      case (bus.wr_addr)
        REG_SR: begin
          sr_d.im  = bus.din[SR_IM_LSB +: IRQW];
          sr_d.exl = bus.din[SR_EXL_BIT];
          sr_d.ie  = bus.din[SR_IE_BIT];
        end
        REG_EPC: epc_d = bus.din[31:2];
        default: ;
      endcase
    end

    // eret clears EXL even over a same-cycle SR write; a taken exception keeps it set.
    if (bus.exl_clr && !req_c) begin
      sr_d.exl = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= EPC_RESET[31:2];
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.int_req = req_c;
  assign bus.epc     = {epc_q, 2'b00};

  // mfc0 read port, no bypass from a same-cycle mtc0.
  always_comb begin
    bus.dout = '0;
    case (bus.rd_addr)
      REG_SR:    bus.dout = sr_word(sr_q);
      REG_CAUSE: bus.dout = cause_word(cause_q);
      REG_EPC:   bus.dout = {epc_q, 2'b00};
      REG_PRID:  bus.dout = PRID;
      default:   bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed plus randomized bench for cp0_intc against a word-level reference model.
module tb_cp0_intc;

  localparam logic [31:0] PRID      = 32'h0000_2016;
  localparam logic [31:0] EPC_RESET = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  cp0_intc_if bus ();

  cp0_intc #(.PRID(PRID), .EPC_RESET(EPC_RESET)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state kept as full architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [4:0]  codes [4] = '{5'd4, 5'd5, 5'd10, 5'd12};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_irq();
    return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    if (!reset) return 1'b0;
    return m_irq() || (bus.exc_valid && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_sr    = 32'd0;
    m_cause = 32'd0;
    m_epc   = EPC_RESET;
  endtask

  // Architectural effect of one rising edge, evaluated with the inputs of that cycle.
  task automatic m_edge();
    logic        req, irq;
    logic [31:0] ns, nc, ne;
    if (!reset) begin
      m_reset();
      return;
    end
    req = m_req();
    irq = m_irq();
    ns  = m_sr;
    nc  = m_cause;
    ne  = m_epc;
    nc[15:10] = bus.hw_int;
    if (req) begin
      ns[1]    = 1'b1;
      nc[31]   = bus.bd;
      nc[6:2]  = irq ? 5'd0 : bus.exc_code;
      ne       = (bus.bd ? bus.pc - 32'd4 : bus.pc) & 32'hFFFF_FFFC;
    end else if (bus.we) begin
      if (bus.wr_addr == 5'd12) ns = bus.din & 32'h0000_FC03;
      if (bus.wr_addr == 5'd14) ne = bus.din & 32'hFFFF_FFFC;
    end
    if (bus.exl_clr && !req) ns[1] = 1'b0;
    m_sr    = ns;
    m_cause = nc;
    m_epc   = ne;
  endtask

  task automatic settle(input string tag);
    #1;
    check({tag, ".int_req"}, {31'd0, bus.int_req}, {31'd0, m_req()});
    check({tag, ".epc"}, bus.epc, m_epc);
    check({tag, ".dout"}, bus.dout, m_read(bus.rd_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.we        = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.din       = 32'd0;
    bus.exc_valid = 1'b0;
    bus.exc_code  = 5'd0;
    bus.exl_clr   = 1'b0;
    bus.hw_int    = 6'd0;
    bus.bd        = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we      = 1'b1;
    bus.wr_addr = a;
    bus.din     = d;
    settle("mtc0");
    tick();
    bus.we = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    idle();
    bus.pc      = 32'h0000_3000;
    bus.rd_addr = 5'd12;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    settle("rst");
    check("rst_epc", bus.epc, 32'h0000_3000);
    check("rst_sr", bus.dout, 32'd0);
    tick();

    // Interrupt via IM[0]/IE
    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001; bus.pc = 32'h0000_3010; bus.rd_addr = 5'd13;
    settle("t2a");
    check("t2_int_req", {31'd0, bus.int_req}, 32'd1);
    tick();
    settle("t2b");
    check("t2_cause", bus.dout, 32'h0000_0400);
    check("t2_epc", bus.epc, 32'h0000_3010);
    check("t2_masked", {31'd0, bus.int_req}, 32'd0);
    bus.rd_addr = 5'd12;
    settle("t2c");
    check("t2_sr", bus.dout, 32'h0000_0403);

    // EXL masks exceptions and pending lines; eret releases them
    bus.exc_valid = 1'b1; bus.exc_code = 5'd12;
    settle("t3a");
    check("t3_exl_mask", {31'd0, bus.int_req}, 32'd0);
    tick();
    bus.exc_valid = 1'b0; bus.exl_clr = 1'b1;
    settle("t3b");
    check("t3_eret_cycle", {31'd0, bus.int_req}, 32'd0);
    tick();
    bus.exl_clr = 1'b0; bus.pc = 32'h0000_3014;
    settle("t3c");
    check("t3_after_eret", {31'd0, bus.int_req}, 32'd1);
    tick();
    bus.hw_int = 6'd0; bus.exl_clr = 1'b1;
    bus.we = 1'b1; bus.wr_addr = 5'd12; bus.din = 32'h0000_0403;
    settle("t3d");
    tick();
    idle(); bus.rd_addr = 5'd12;
    settle("t3e");
    check("t3_clear_wins", bus.dout, 32'h0000_0401);

    // Synchronous exception in a delay slot with IE=0
    mtc0(5'd12, 32'd0);
    bus.exc_valid = 1'b1; bus.exc_code = 5'd12; bus.bd = 1'b1; bus.pc = 32'h0000_3024;
    settle("t4a");
    check("t4_int_req", {31'd0, bus.int_req}, 32'd1);
    tick();
    idle(); bus.rd_addr = 5'd13;
    settle("t4b");
    check("t4_cause", bus.dout, 32'h8000_0030);
    check("t4_epc", bus.epc, 32'h0000_3020);
    tick();
    bus.exl_clr = 1'b1;
    settle("t4c");
    tick();
    idle();

    // Interrupt outranks exception; same-cycle mtc0 dropped
    mtc0(5'd12, 32'h0000_FC01);
    bus.hw_int = 6'b100000; bus.exc_valid = 1'b1; bus.exc_code = 5'd10;
    bus.pc = 32'h0000_3040; bus.we = 1'b1; bus.wr_addr = 5'd14; bus.din = 32'h0000_1234;
    settle("t5a");
    check("t5_int_req", {31'd0, bus.int_req}, 32'd1);
    tick();
    idle(); bus.rd_addr = 5'd13;
    settle("t5b");
    check("t5_cause", bus.dout, 32'h0000_8000);
    check("t5_epc", bus.epc, 32'h0000_3040);
    tick();
    bus.exl_clr = 1'b1;
    settle("t5c");
    tick();
    idle();

    // EPC alignment, unmapped and PRId reads
    mtc0(5'd14, 32'h0000_3007);
    bus.rd_addr = 5'd14;
    settle("t6a");
    check("t6_epc_rd", bus.dout, 32'h0000_3004);
    bus.rd_addr = 5'd16;
    settle("t6b");
    check("t6_unmapped", bus.dout, 32'd0);
    bus.rd_addr = 5'd15;
    settle("t6c");
    check("t6_prid", bus.dout, 32'h0000_2016);
    tick();

    // Asynchronous reset mid-run with requests still pending
    bus.exc_valid = 1'b1; bus.exc_code = 5'd4; bus.pc = 32'h0000_3050;
    settle("t1a");
    tick();
    bus.hw_int = 6'h3F;
    #2;
    reset = 1'b0;
    m_reset();
    bus.rd_addr = 5'd12;
    settle("t1b");
    check("t1_int_req", {31'd0, bus.int_req}, 32'd0);
    check("t1_epc", bus.epc, 32'h0000_3000);
    check("t1_sr", bus.dout, 32'd0);
    bus.rd_addr = 5'd13;
    settle("t1c");
    check("t1_cause", bus.dout, 32'd0);
    tick();
    reset = 1'b1;
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        m_reset();
      end else begin
        reset = 1'b1;
      end
      bus.hw_int    = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
      bus.exc_valid = ($urandom_range(0, 7) == 0);
      bus.exc_code  = codes[$urandom_range(0, 3)];
      bus.bd        = 1'($urandom_range(0, 1));
      bus.pc        = $urandom() & 32'hFFFF_FFFC;
      bus.we        = ($urandom_range(0, 2) == 0);
      bus.wr_addr   = 5'($urandom_range(11, 16));
      bus.din       = $urandom();
      bus.exl_clr   = ($urandom_range(0, 4) == 0);
      bus.rd_addr   = 5'($urandom_range(10, 17));
      settle("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
